// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - leaky integrate-and-fire neuron core
// Three-state step sequencer: capture input, leak+integrate, threshold check.
module lif_neuron_core #(
  parameter int RESET_MODE = 0,
  parameter int REFR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [4:0]            input_current,
  input  logic [6:0]            threshold,
  input  logic [2:0]            decay_shift,
  input  logic [REFR_WIDTH-1:0] refractory_period,
  input  logic                  count_clear,
  output logic                  busy,
  output logic                  done,
  output logic                  spike_out,
  output logic [7:0]            membrane_potential,
  output logic [7:0]            spike_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, CHECK = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [4:0]            cur_q;
  logic                  refr_step_q;
  logic [REFR_WIDTH-1:0] refr_cnt;
  logic [7:0]            v_q;
  logic [7:0]            cnt_q;
  logic                  done_q;
  logic                  spike_q;

  logic                  accept;
  logic                  in_refr;
  logic                  fire;
  logic signed [7:0]     v_s;
  logic signed [7:0]     leak;
  logic signed [9:0]     sum;
  logic [7:0]            v_sat;

  assign accept  = (state == IDLE) && enable;
  assign in_refr = (refr_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = UPDATE;
      UPDATE:  state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A shift of 0 would otherwise leak the whole potential away.
  always_comb begin
    v_s   = $signed(v_q);
    leak  = (decay_shift == 3'd0) ? 8'sd0 : (v_s >>> decay_shift);
    sum   = $signed({{2{v_q[7]}}, v_q}) - $signed({{2{leak[7]}}, leak})
          + $signed({{5{cur_q[4]}}, cur_q});
    v_sat = sum[7:0];
    if (sum > 10'sd127)       v_sat = 8'h7f;
    else if (sum < -10'sd128) v_sat = 8'h80;
  end

  assign fire = (state == CHECK) && !refr_step_q &&
                ($signed(v_q) >= $signed({1'b0, threshold}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= '0;
      refr_step_q <= 1'b0;
      refr_cnt    <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      spike_q     <= 1'b0;
    end else begin
      done_q  <= (state == CHECK);
      spike_q <= fire;

      if (accept) begin
        refr_step_q <= in_refr;
        cur_q       <= in_refr ? 5'd0 : input_current;
      end

      if (state == UPDATE)
        v_q <= v_sat;
      else if (fire)
        v_q <= (RESET_MODE == 0) ? 8'd0 : (v_q - {1'b0, threshold});

      if (state == CHECK) begin
        if (refr_step_q) refr_cnt <= refr_cnt - REFR_WIDTH'(1);
        else if (fire)   refr_cnt <= refractory_period;
      end

      // Clear has priority over a coincident spike increment.
      if (count_clear) cnt_q <= '0;
      else if (fire)   cnt_q <= cnt_q + 8'd1;
    end
  end

  assign busy               = (state != IDLE);
  assign done               = done_q;
  assign spike_out          = spike_q;
  assign membrane_potential = v_q;
  assign spike_count        = cnt_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb/tb_lif_neuron_core.sv - self-checking bench for lif_neuron_core
// Both reset modes run side by side against an arithmetic reference model.
module tb_lif_neuron_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] input_current = '0;
  logic [6:0] threshold = '0;
  logic [2:0] decay_shift = '0;
  logic [3:0] refractory_period = '0;
  logic       count_clear = 1'b0;

  logic       busy0, done0, spike0, busy1, done1, spike1;
  logic [7:0] v0, v1, cnt0, cnt1;

  int nvec = 0;
  int nerr = 0;
  int mv[2];
  int mrefr[2];
  int mcnt[2];

  always #5 clk = ~clk;

  lif_neuron_core #(.RESET_MODE(0), .REFR_WIDTH(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .input_current(input_current),
    .threshold(threshold), .decay_shift(decay_shift), .refractory_period(refractory_period),
    .count_clear(count_clear), .busy(busy0), .done(done0), .spike_out(spike0),
    .membrane_potential(v0), .spike_count(cnt0)
  );

  lif_neuron_core #(.RESET_MODE(1), .REFR_WIDTH(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .input_current(input_current),
    .threshold(threshold), .decay_shift(decay_shift), .refractory_period(refractory_period),
    .count_clear(count_clear), .busy(busy1), .done(done1), .spike_out(spike1),
    .membrane_potential(v1), .spike_count(cnt1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_v(input int m);
    int r;
    r = (m == 0) ? int'($signed(v0)) : int'($signed(v1));
    return r;
  endfunction

  function automatic int dut_spike(input int m);
    return (m == 0) ? int'(spike0) : int'(spike1);
  endfunction

  function automatic int dut_cnt(input int m);
    return (m == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mrefr[m] = 0; mcnt[m] = 0;
    end
  endfunction

  // Leak is floor(V / 2^shift); mode 0 resets to zero, mode 1 subtracts threshold.
  function automatic int model_step(input int m, input int cur, input bit clr);
    int v, d, leak, i, spk;
    bit refr;
    v    = mv[m];
    d    = 1 << int'(decay_shift);
    refr = (mrefr[m] > 0);
    i    = refr ? 0 : cur;
    if (decay_shift == 0) leak = 0;
    else if (v >= 0)      leak = v / d;
    else                  leak = -((-v + d - 1) / d);
    v = v - leak + i;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    spk = 0;
    if (refr) mrefr[m]--;
    else if (v >= int'(threshold)) begin
      spk      = 1;
      v        = (m == 0) ? 0 : v - int'(threshold);
      mrefr[m] = int'(refractory_period);
      mcnt[m]  = (mcnt[m] + 1) % 256;
    end
    if (clr) mcnt[m] = 0;
    mv[m] = v;
    return spk;
  endfunction

  task automatic check_against_model(input int m, input int spk);
    chk($sformatf("spike_m%0d", m), dut_spike(m), spk);
    chk($sformatf("vmem_m%0d", m), dut_v(m), mv[m]);
    chk($sformatf("count_m%0d", m), dut_cnt(m), mcnt[m]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy0 | busy1), 0);
    chk("rst_done", int'(done0 | done1), 0);
    chk("rst_spike", int'(spike0 | spike1), 0);
    chk("rst_v", int'(v0 | v1), 0);
    chk("rst_cnt", int'(cnt0 | cnt1), 0);
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  // Called on a negedge with the DUT idle; drives one accepted step.
  task automatic step(input int cur, input bit clr);
    int k;
    int spk;
    bit found;
    input_current = cur[4:0];
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("busy_after_accept", int'(busy0), 1);
    chk("done_early", int'(done0), 0);
    k = 0;
    found = 1'b0;
    for (int n = 0; n < 4; n++) begin
      count_clear = clr && (k == 1);
      @(negedge clk);
      k++;
      if (done0) begin
        found = 1'b1;
        break;
      end
    end
    count_clear = 1'b0;
    chk("latency", k, 2);
    chk("done_pair", int'(done1), int'(found));
    chk("busy_at_done", int'(busy0), 0);
    for (int m = 0; m < 2; m++) begin
      spk = model_step(m, cur, clr);
      check_against_model(m, spk);
    end
  endtask

  task automatic set_cfg(input int t, input int d, input int p);
    threshold         = t[6:0];
    decay_shift       = d[2:0];
    refractory_period = p[3:0];
  endtask

  initial begin
    int ndone;
    int spk;
    int cur;

    model_clear();
    do_reset();

    // Integrate and fire: +3 per step, threshold 10
    set_cfg(10, 0, 0);
    for (int s = 1; s <= 7; s++) begin
      step(3, 1'b0);
      if (s == 4) begin
        chk("if_spike4", int'(spike0), 1);
        chk("if_v0_after", dut_v(0), 0);
        chk("if_cnt", int'(cnt0), 1);
        chk("sub_v1_after", dut_v(1), 2);
      end
      if (s == 7) chk("sub_spike7", int'(spike1), 1);
    end

    // Leak with shift 2
    do_reset();
    set_cfg(127, 2, 0);
    step(15, 1'b0); step(15, 1'b0); step(15, 1'b0);
    chk("leak_v36", dut_v(0), 36);
    step(0, 1'b0);
    chk("leak_v27", dut_v(0), 27);

    // Positive saturation then firing at 127
    do_reset();
    set_cfg(127, 0, 0);
    for (int s = 1; s <= 9; s++) begin
      step(15, 1'b0);
      if (s == 8) chk("sat_v120", dut_v(0), 120);
    end
    chk("sat_fire9", int'(spike0), 1);

    // Negative saturation
    do_reset();
    for (int s = 1; s <= 10; s++) step(-16, 1'b0);
    chk("nsat_v", dut_v(0), -128);
    chk("nsat_cnt", int'(cnt0), 0);

    // Refractory window
    do_reset();
    set_cfg(5, 0, 2);
    for (int s = 1; s <= 4; s++) begin
      step(15, 1'b0);
      chk($sformatf("refr_spike%0d", s), int'(spike0), (s == 1 || s == 4) ? 1 : 0);
    end

    // Enable held high: one step per 3 cycles
    do_reset();
    set_cfg(20, 1, 1);
    input_current = 5'd7;
    enable = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        for (int m = 0; m < 2; m++) begin
          spk = model_step(m, 7, 1'b0);
          check_against_model(m, spk);
        end
      end
    end
    enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("hold_enable_steps", ndone, 10);

    // Reset pulsed while in UPDATE
    do_reset();
    set_cfg(5, 0, 0);
    step(15, 1'b0);
    step(15, 1'b0);
    input_current = 5'd9;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy0 | busy1), 0);
    chk("midrst_v", int'(v0 | v1), 0);
    chk("midrst_cnt", int'(cnt0 | cnt1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0 | done1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Counter: clear coincident with spike at 255, then a full wrap
    do_reset();
    set_cfg(0, 0, 0);
    for (int s = 0; s < 255; s++) step(0, 1'b0);
    chk("cnt_255", int'(cnt0), 255);
    step(0, 1'b1);
    chk("cnt_clear_wins", int'(cnt0), 0);
    for (int s = 0; s < 256; s++) step(0, 1'b0);
    chk("cnt_wrap", int'(cnt0), 0);

    // Randomized steps with live-sampled configuration changes between steps
    do_reset();
    for (int s = 0; s < 300; s++) begin
      set_cfg(int'($urandom_range(0, 40)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)));
      cur = int'($urandom_range(0, 31)) - 16;
      step(cur, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
